// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, PC defaults and branch opcode.
package fetch_pkg;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_BR_WAIT = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  localparam logic [1:0] OPC_BRANCH = 2'b11;

  function automatic logic is_branch(input logic [31:0] instr);
    return instr[31:30] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC selection: reset, redirect, sequential increment or hold.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Redirect outranks the increment so a flush never lets a stale fetch move the PC.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests one word, holds it for decode, then fetches the next.
// Optional macro BRANCH_STALL_EN adds a BR_WAIT stall after delivering a branch opcode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        branch_resolved,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  logic [1:0]  state_d, state_q;
  logic        out_valid_d, out_valid_q;
  logic [31:0] out_instruction_d, out_instruction_q;
  logic [31:0] out_pc_d, out_pc_q;
  logic [31:0] pc;
  logic        accept;

`ifndef BRANCH_STALL_EN
  logic unused_branch_resolved;
  assign unused_branch_resolved = branch_resolved;
`endif

  // The request drops for a redirect cycle so a coincident ack can never be taken.
  assign imem_req  = !rst && !redirect && (state_q == ST_FETCH);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;

  fetch_pc #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_fetch_pc (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (accept),
    .pc          (pc)
  );

  always_comb begin
    state_d           = state_q;
    out_valid_d       = out_valid_q;
    out_instruction_d = out_instruction_q;
    out_pc_d          = out_pc_q;

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          out_instruction_d = imem_rdata;
          out_pc_d          = pc;
          out_valid_d       = 1'b1;
          state_d           = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
`ifdef BRANCH_STALL_EN
          if (is_branch(out_instruction_q)) begin
            state_d = ST_BR_WAIT;
          end
`endif
        end
      end
`ifdef BRANCH_STALL_EN
      ST_BR_WAIT: begin
        if (branch_resolved) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    // A redirect wins over everything, including a handshake already in progress.
    if (redirect) begin
      out_valid_d = 1'b0;
      state_d     = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_FETCH;
      out_valid_q       <= 1'b0;
      out_instruction_q <= 32'h0;
      out_pc_q          <= 32'h0;
    end else begin
      state_q           <= state_d;
      out_valid_q       <= out_valid_d;
      out_instruction_q <= out_instruction_d;
      out_pc_q          <= out_pc_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_instruction = out_instruction_q;
  assign out_pc          = out_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetch/deliver vectors plus redirect, reset, wrap
// and branch-stall sequences. Build with BRANCH_STALL_EN defined to exercise the BR_WAIT path.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ackDelay;
    int          readyDelay;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        branch_resolved;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_branch_resolved;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instruction;
  logic [31:0] w_out_pc;

  exp_t sbQ[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  // Free-running 10-unit clock shared by both instances.
  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .branch_resolved(branch_resolved),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .branch_resolved(w_branch_resolved),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instruction(w_out_instruction), .out_pc(w_out_pc)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pops the expected delivery and compares it with what decode sees this cycle.
  task automatic deliver(input string name);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got out_pc %h but scoreboard empty", name, out_pc);
    end else begin
      e = sbQ.pop_front();
      checkOutput({name, "_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({name, "_instr"}, out_instruction, e.instr);
      checkOutput({name, "_pc"}, out_pc, e.pc);
    end
  endtask

  // One full fetch: optional memory wait, ack, optional back-pressure, then the handshake.
  task automatic applyStimulus(input vec_t v);
    redirect  = 1'b0;
    out_ready = 1'b0;
    imem_ack  = 1'b0;
    for (int k = 0; k < v.ackDelay; k++) begin
      #1;
      checkOutput("req_wait", {31'b0, imem_req}, 32'd1);
      checkOutput("addr_wait", imem_addr, v.addr);
      checkOutput("valid_idle", {31'b0, out_valid}, 32'd0);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = v.data;
    #1;
    checkOutput("req", {31'b0, imem_req}, 32'd1);
    checkOutput("addr", imem_addr, v.addr);
    sbQ.push_back('{pc: v.addr, instr: v.data});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    for (int k = 0; k < v.readyDelay; k++) begin
      #1;
      checkOutput("valid_hold", {31'b0, out_valid}, 32'd1);
      checkOutput("req_hold", {31'b0, imem_req}, 32'd0);
      checkOutput("instr_stable", out_instruction, v.data);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("req_deliver", {31'b0, imem_req}, 32'd0);
    deliver("deliver");
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, data: 32'h4000_0000, ackDelay: 0, readyDelay: 5};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h1234_5678, ackDelay: 2, readyDelay: 0};
    vecs[2] = '{addr: 32'h0000_0008, data: 32'h0000_0013, ackDelay: 0, readyDelay: 1};
    vecs[3] = '{addr: 32'h0000_000C, data: 32'hBEAD_BEEF, ackDelay: 1, readyDelay: 2};
    vecs[4] = '{addr: 32'h0000_0010, data: 32'h7FFF_FFFF, ackDelay: 0, readyDelay: 0};
    vecs[5] = '{addr: 32'h0000_0014, data: 32'h0000_0000, ackDelay: 3, readyDelay: 0};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; branch_resolved = 1'b0; out_ready = 1'b0;
    w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'h0; w_redirect = 1'b0;
    w_redirect_pc = 32'h0; w_branch_resolved = 1'b0; w_out_ready = 1'b0;

    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
      checkOutput("rst_instr", out_instruction, 32'h0);
      checkOutput("rst_outpc", out_pc, 32'h0);
    end
    rst = 1'b0;
    #1;
    checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Redirect with a coincident ack: the word must be dropped and fetch restarts at 0x100.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    checkOutput("redir_req_low", {31'b0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    #1;
    checkOutput("redir_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus('{addr: 32'h0000_0100, data: 32'h1111_0000, ackDelay: 0, readyDelay: 0});

    // Redirect coincident with a handshake: the word is delivered and pc takes the target.
    imem_ack = 1'b1; imem_rdata = 32'h2222_0000;
    #1;
    checkOutput("hs_redir_addr", imem_addr, 32'h0000_0104);
    sbQ.push_back('{pc: 32'h0000_0104, instr: 32'h2222_0000});
    tick();
    imem_ack = 1'b0; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    checkOutput("hs_redir_req", {31'b0, imem_req}, 32'd0);
    deliver("hs_redir");
    tick();
    redirect = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput("hs_redir_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("hs_redir_req2", {31'b0, imem_req}, 32'd1);
    checkOutput("hs_redir_addr2", imem_addr, 32'h0000_0200);

    // Reset while holding a valid word.
    imem_ack = 1'b1; imem_rdata = 32'h3333_0000;
    tick();
    imem_ack = 1'b0;
    #1;
    checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("hold_rst_req", {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput("hold_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("hold_rst_instr", out_instruction, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("hold_rst_req2", {31'b0, imem_req}, 32'd1);
    checkOutput("hold_rst_pc", imem_addr, 32'h0);

    applyStimulus('{addr: 32'h0000_0000, data: 32'hC000_0000, ackDelay: 0, readyDelay: 1});
`ifdef BRANCH_STALL_EN
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("brw_req", {31'b0, imem_req}, 32'd0);
      checkOutput("brw_valid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    branch_resolved = 1'b1;
    tick();
    branch_resolved = 1'b0;
    #1;
    checkOutput("brw_res_req", {31'b0, imem_req}, 32'd1);
    checkOutput("brw_res_addr", imem_addr, 32'h0000_0004);
    applyStimulus('{addr: 32'h0000_0004, data: 32'hC000_0001, ackDelay: 0, readyDelay: 0});
    #1;
    checkOutput("brw2_req", {31'b0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0020; branch_resolved = 1'b1;
    tick();
    redirect = 1'b0; branch_resolved = 1'b0;
    #1;
    checkOutput("brw_redir_req", {31'b0, imem_req}, 32'd1);
    checkOutput("brw_redir_addr", imem_addr, 32'h0000_0020);
    applyStimulus('{addr: 32'h0000_0020, data: 32'h0000_5555, ackDelay: 0, readyDelay: 0});
`else
    branch_resolved = 1'b1;
    #1;
    checkOutput("nobr_req", {31'b0, imem_req}, 32'd1);
    checkOutput("nobr_addr", imem_addr, 32'h0000_0004);
    tick();
    branch_resolved = 1'b0;
    applyStimulus('{addr: 32'h0000_0004, data: 32'hC000_0001, ackDelay: 0, readyDelay: 0});
    #1;
    checkOutput("nobr_seq_addr", imem_addr, 32'h0000_0008);
`endif

    // Wrap-around from the top of the address space on the second instance.
    w_rst = 1'b0;
    #1;
    checkOutput("wrap_req1", {31'b0, w_req}, 32'd1);
    checkOutput("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h4444_0000;
    tick();
    w_ack = 1'b0;
    #1;
    checkOutput("wrap_valid", {31'b0, w_out_valid}, 32'd1);
    checkOutput("wrap_outpc", w_out_pc, 32'hFFFF_FFFC);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    #1;
    checkOutput("wrap_req2", {31'b0, w_req}, 32'd1);
    checkOutput("wrap_addr2", w_addr, 32'h0000_0000);

    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
